// File: rtl/nrisc_ctrl_fsm.sv
// Purpose : NRISC control FSM; decodes one 16-bit instruction at a time and drives the datapath strobes.
// Latency : outputs registered; EXEC strobes appear the cycle after instr_valid && instr_ready.
// Backpress: instr_ready high only in FETCH; MEM holds mem_req until mem_ack or MEM_TIMEOUT expires.
//
// Ports: clk/rst (async active-high); instr/instr_valid/instr_ready fetch handshake; flags {C,Z,M};
//        ula_ctrl/ula_incdec, reg_rd/rf1/rf2/we, imm_sel/data_sel, addr_le/mem_req/mem_we/mem_ack,
//        stack_push/pop, pc_sel/pc_en, state code and sticky fault.
// Option : define NRISC_CTRL_IRQ_EN to add irq/irq_ack and the interrupt-enable flag.
module nrisc_ctrl_fsm #(
    parameter int STACK_DEPTH = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  flags,
    output logic [3:0]  ula_ctrl,
    output logic        ula_incdec,
    output logic [3:0]  reg_rd,
    output logic [3:0]  reg_rf1,
    output logic [3:0]  reg_rf2,
    output logic        reg_we,
    output logic        imm_sel,
    output logic        data_sel,
    output logic        addr_le,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        stack_push,
    output logic        stack_pop,
    output logic [1:0]  pc_sel,
    output logic        pc_en,
`ifdef NRISC_CTRL_IRQ_EN
    input  logic        irq,
    output logic        irq_ack,
`endif
    output logic [2:0]  state,
    output logic        fault
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    typedef struct packed {
        logic       instr_ready;
        logic [3:0] ula_ctrl;
        logic       ula_incdec;
        logic [3:0] reg_rd;
        logic [3:0] reg_rf1;
        logic [3:0] reg_rf2;
        logic       reg_we;
        logic       imm_sel;
        logic       data_sel;
        logic       addr_le;
        logic       mem_req;
        logic       mem_we;
        logic       stack_push;
        logic       stack_pop;
        logic [1:0] pc_sel;
        logic       pc_en;
        logic       fault;
`ifdef NRISC_CTRL_IRQ_EN
        logic       irq_ack;
`endif
    } out_t;

    state_t          state_q, state_d;
    state_t          tgt_q, tgt_d;      // where EXEC goes next, decided at fetch time
    logic [15:0]     ir_q, ir_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [TW-1:0]   tmr_q, tmr_d;      // index of the current mem_req cycle, 1-based
    logic            done_q, done_d;    // MEM is in its post-ack completion cycle
    out_t            o_q, o_d;
`ifdef NRISC_CTRL_IRQ_EN
    logic            ie_q, ie_d;
`endif

    // Outputs held while MEM waits for mem_ack; SW routes IR[11:8] to both read ports.
    function automatic out_t mem_wait_out(input logic [15:0] ir);
        out_t o;
        o         = '0;
        o.mem_req = 1'b1;
        o.reg_rd  = ir[11:8];
        if (ir[15:12] == 4'h2) begin
            o.mem_we   = 1'b1;
            o.reg_rf1  = ir[11:8];
            o.reg_rf2  = ir[11:8];
            o.ula_ctrl = 4'h2;
        end else begin
            o.reg_rf1 = ir[7:4];
            o.reg_rf2 = ir[3:0];
        end
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        ir_d    = ir_q;
        depth_d = depth_q;
        tmr_d   = tmr_q;
        done_d  = done_q;
`ifdef NRISC_CTRL_IRQ_EN
        ie_d    = ie_q;
`endif
        o_d     = '0;

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    // Decode straight from the bus so the EXEC strobes are registered on entry.
                    ir_d        = instr;
                    state_d     = S_EXEC;
                    tgt_d       = S_FETCH;
                    o_d.reg_rd  = instr[11:8];
                    o_d.reg_rf1 = instr[7:4];
                    o_d.reg_rf2 = instr[3:0];
                    case (instr[15:12])
                        4'h0: begin
                            case (instr[11:8])
                                4'h0, 4'h2: o_d.pc_en = 1'b1;
                                4'h1, 4'h3: tgt_d = S_HALT;
                                4'h4: begin
                                    if (depth_q < DW'(STACK_DEPTH)) begin
                                        o_d.stack_push = 1'b1;
                                        o_d.pc_sel     = 2'd1;
                                        o_d.pc_en      = 1'b1;
                                        depth_d        = depth_q + DW'(1);
                                    end else begin
                                        tgt_d = S_FAULT;
                                    end
                                end
                                4'h5, 4'h6: begin
                                    if (depth_q != '0) begin
                                        o_d.stack_pop = 1'b1;
                                        o_d.pc_sel    = 2'd2;
                                        o_d.pc_en     = 1'b1;
                                        depth_d       = depth_q - DW'(1);
`ifdef NRISC_CTRL_IRQ_EN
                                        if (instr[11:8] == 4'h6) ie_d = 1'b1;
`endif
                                    end else begin
                                        tgt_d = S_FAULT;
                                    end
                                end
                                default: tgt_d = S_FAULT;
                            endcase
                        end
                        4'h1, 4'h2: begin
                            o_d.addr_le = 1'b1;
                            tgt_d       = S_MEM;
                        end
                        4'h3: begin
                            o_d.imm_sel = 1'b1;
                            o_d.reg_we  = 1'b1;
                            o_d.pc_en   = 1'b1;
                        end
                        4'h4: begin
                            o_d.pc_sel = 2'd1;
                            o_d.pc_en  = 1'b1;
                        end
                        4'h5: begin
                            o_d.pc_sel = {1'b0, flags[1]};
                            o_d.pc_en  = 1'b1;
                        end
                        4'h6: begin
                            o_d.pc_sel = {1'b0, flags[2]};
                            o_d.pc_en  = 1'b1;
                        end
                        4'h7: begin
                            o_d.pc_sel = {1'b0, flags[0]};
                            o_d.pc_en  = 1'b1;
                        end
                        4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
                            o_d.ula_ctrl = instr[15:12] - 4'h8;
                            o_d.reg_we   = 1'b1;
                            o_d.pc_en    = 1'b1;
                        end
                        4'hD, 4'hE: begin
                            o_d.ula_ctrl = (instr[15:12] == 4'hD) ? {instr[0], 3'h5} : {instr[0], 3'h6};
                            o_d.reg_we   = 1'b1;
                            o_d.pc_en    = 1'b1;
                        end
                        default: begin  // 4'hF unary group
                            o_d.reg_we = 1'b1;
                            o_d.pc_en  = 1'b1;
                            case (instr[3:0])
                                4'h0: o_d.ula_ctrl = 4'h7;
                                4'h1: o_d.ula_ctrl = 4'h8;
                                4'h2: o_d.ula_incdec = 1'b1;
                                4'h3: begin
                                    o_d.ula_ctrl   = 4'h1;
                                    o_d.ula_incdec = 1'b1;
                                end
                                default: begin
                                    o_d.reg_we = 1'b0;
                                    o_d.pc_en  = 1'b0;
                                    tgt_d      = S_FAULT;
                                end
                            endcase
                        end
                    endcase
                end
            end
            S_EXEC: begin
                state_d = tgt_q;
                if (tgt_q == S_MEM) begin
                    o_d    = mem_wait_out(ir_q);
                    tmr_d  = TW'(1);
                    done_d = 1'b0;
                end
            end
            S_MEM: begin
                if (done_q) begin
                    state_d = S_FETCH;
                end else if (mem_ack) begin
                    // Completion cycle stays in MEM so the write/PC strobes remain MEM-only pulses.
                    done_d      = 1'b1;
                    o_d.reg_rd  = ir_q[11:8];
                    o_d.reg_rf1 = ir_q[7:4];
                    o_d.reg_rf2 = ir_q[3:0];
                    o_d.pc_en   = 1'b1;
                    if (ir_q[15:12] == 4'h1) begin
                        o_d.data_sel = 1'b1;
                        o_d.reg_we   = 1'b1;
                    end
                end else if (tmr_q == TW'(MEM_TIMEOUT)) begin
                    state_d = S_FAULT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                    o_d   = mem_wait_out(ir_q);
                end
            end
            S_HALT, S_FAULT: ;
            default: state_d = S_FAULT;
        endcase

`ifdef NRISC_CTRL_IRQ_EN
        // Interrupt entry borrows one EXEC cycle for its strobes and wins over instr_valid.
        if (irq && ie_q && (depth_q < DW'(STACK_DEPTH)) &&
            (state_q == S_FETCH || state_q == S_HALT)) begin
            state_d        = S_EXEC;
            tgt_d          = S_FETCH;
            ir_d           = ir_q;
            depth_d        = depth_q + DW'(1);
            ie_d           = 1'b0;
            o_d            = '0;
            o_d.stack_push = 1'b1;
            o_d.pc_sel     = 2'd3;
            o_d.pc_en      = 1'b1;
            o_d.irq_ack    = 1'b1;
        end
`endif

        o_d.instr_ready = (state_d == S_FETCH);
        o_d.fault       = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_FETCH;
            tgt_q             <= S_FETCH;
            ir_q              <= '0;
            depth_q           <= '0;
            tmr_q             <= '0;
            done_q            <= 1'b0;
            o_q               <= '0;
            o_q.instr_ready   <= 1'b1;
`ifdef NRISC_CTRL_IRQ_EN
            ie_q              <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            ir_q    <= ir_d;
            depth_q <= depth_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            o_q     <= o_d;
`ifdef NRISC_CTRL_IRQ_EN
            ie_q    <= ie_d;
`endif
        end
    end

    assign instr_ready = o_q.instr_ready;
    assign ula_ctrl    = o_q.ula_ctrl;
    assign ula_incdec  = o_q.ula_incdec;
    assign reg_rd      = o_q.reg_rd;
    assign reg_rf1     = o_q.reg_rf1;
    assign reg_rf2     = o_q.reg_rf2;
    assign reg_we      = o_q.reg_we;
    assign imm_sel     = o_q.imm_sel;
    assign data_sel    = o_q.data_sel;
    assign addr_le     = o_q.addr_le;
    assign mem_req     = o_q.mem_req;
    assign mem_we      = o_q.mem_we;
    assign stack_push  = o_q.stack_push;
    assign stack_pop   = o_q.stack_pop;
    assign pc_sel      = o_q.pc_sel;
    assign pc_en       = o_q.pc_en;
    assign fault       = o_q.fault;
    assign state       = state_q;
`ifdef NRISC_CTRL_IRQ_EN
    assign irq_ack     = o_q.irq_ack;
`endif

endmodule
